// File: rtl/echo_queue_if.sv
// Handshake bundle for echo_queue: say request side, respond rule scheduling,
// heard indication side and occupancy monitor.
interface echo_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
);
  logic                  say__ENA;
  logic [DATA_WIDTH-1:0] say_v;
  logic                  say__RDY;
  logic                  respond_rule__ENA;
  logic                  respond_rule__RDY;
  logic                  ind_heard__ENA;
  logic [DATA_WIDTH-1:0] ind_heard_heard_v;
  logic                  ind_heard__RDY;
  logic                  rule_enable;
  logic                  rule_ready;
  logic [CNT_W-1:0]      count;

  modport master (
    output say__ENA, say_v, respond_rule__ENA, ind_heard__RDY, rule_enable,
    input  say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_heard_v,
           rule_ready, count
  );

  modport slave (
    input  say__ENA, say_v, respond_rule__ENA, ind_heard__RDY, rule_enable,
    output say__RDY, respond_rule__RDY, ind_heard__ENA, ind_heard_heard_v,
           rule_ready, count
  );
endinterface

// File: rtl/echo_queue.sv
// DEPTH-entry ring buffer echoing say requests onto the heard indication.
// Define ECHO_QUEUE_BYPASS_EN for a zero-latency pass-through when empty.
module echo_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic       CLK,
  input  logic       nRST,
  echo_queue_if.slave q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic say_rdy, rule_rdy, fire, enq, deq, bypass_fire;
  logic [DATA_WIDTH-1:0] heard_v;

  always_comb begin
    say_rdy     = (count_q != CNT_W'(DEPTH));
    rule_rdy    = (count_q != '0) && q.ind_heard__RDY;
    bypass_fire = 1'b0;
`ifdef ECHO_QUEUE_BYPASS_EN
    // Empty queue with a word arriving: offer it straight to the consumer.
    if (count_q == '0 && q.say__ENA)
      rule_rdy = q.ind_heard__RDY;
`endif
    fire = (q.respond_rule__ENA || q.rule_enable) && rule_rdy;
`ifdef ECHO_QUEUE_BYPASS_EN
    bypass_fire = fire && (count_q == '0);
`endif
    enq     = q.say__ENA && say_rdy && !bypass_fire;
    deq     = fire && !bypass_fire;
    heard_v = bypass_fire ? q.say_v : mem_q[rptr_q];

    wptr_d  = enq ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = deq ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (enq)
      mem_q[wptr_q] <= q.say_v;
  end

  assign q.say__RDY          = say_rdy;
  assign q.respond_rule__RDY = rule_rdy;
  assign q.rule_ready        = rule_rdy;
  assign q.ind_heard__ENA    = fire;
  assign q.ind_heard_heard_v = heard_v;
  assign q.count             = count_q;
endmodule

// File: tb/tb_echo_queue.sv
// Directed self-checking bench for echo_queue; expectations are hand-computed.
module tb_echo_queue;
  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

  echo_queue_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();
  echo_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (.CLK(CLK), .nRST(nRST), .q(bus));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.say__ENA          = 1'b0;
    bus.say_v             = '0;
    bus.respond_rule__ENA = 1'b0;
    bus.rule_enable       = 1'b0;
    bus.ind_heard__RDY    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.say__RDY !== 1'b1 || bus.respond_rule__RDY !== 1'b0 ||
        bus.rule_ready !== 1'b0 || bus.ind_heard__ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d say_rdy=%b rr_rdy=%b rule_ready=%b ena=%b, want 0 1 0 0 0",
               bus.count, bus.say__RDY, bus.respond_rule__RDY, bus.rule_ready, bus.ind_heard__ENA);
    end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    bus.ind_heard__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.say__ENA = 1'b1;
      bus.say_v    = 32'h11 + i;
      @(negedge CLK);
      n_checks++;
      if (bus.say__RDY !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_rdy[%0d]: say__RDY=%b want 1", i, bus.say__RDY);
      end
      tick();
    end
    n_checks++;
    if (bus.count !== 3'd4 || bus.say__RDY !== 1'b0 || bus.respond_rule__RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL full: count=%0d say_rdy=%b rr_rdy=%b want 4 0 0",
               bus.count, bus.say__RDY, bus.respond_rule__RDY);
    end
    bus.say_v = 32'h15;
    tick();
    n_checks++;
    if (bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_drop: count=%0d want 4", bus.count);
    end
    bus.say__ENA = 1'b0;
  endtask

  task automatic test_drain();
    bus.ind_heard__RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      // Alternate between the two fire inputs.
      bus.respond_rule__ENA = (i % 2 == 0);
      bus.rule_enable       = (i % 2 == 1);
      @(negedge CLK);
      n_checks++;
      if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_v !== 32'h11 + i ||
          bus.rule_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL drain[%0d]: ena=%b data=%h rule_ready=%b want 1 %h 1",
                 i, bus.ind_heard__ENA, bus.ind_heard_heard_v, bus.rule_ready, 32'h11 + i);
      end
      tick();
    end
    n_checks++;
    if (bus.count !== 3'd0 || bus.respond_rule__RDY !== 1'b0 || bus.ind_heard__ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: count=%0d rr_rdy=%b ena=%b want 0 0 0",
               bus.count, bus.respond_rule__RDY, bus.ind_heard__ENA);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bus.say__ENA = 1'b1;
    bus.say_v    = 32'h20;
    tick();
    bus.ind_heard__RDY    = 1'b1;
    bus.respond_rule__ENA = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.say_v = 32'h21 + i;
      @(negedge CLK);
      n_checks++;
      if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_v !== 32'h20 + i ||
          bus.count !== 3'd1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: ena=%b data=%h count=%0d want 1 %h 1",
                 i, bus.ind_heard__ENA, bus.ind_heard_heard_v, bus.count, 32'h20 + i);
      end
      tick();
    end
    bus.say__ENA = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.ind_heard_heard_v !== 32'h2A || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_last: data=%h count=%0d want 2a 1", bus.ind_heard_heard_v, bus.count);
    end
    tick();
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_empty: count=%0d want 0", bus.count);
    end
    idle();
  endtask

  task automatic test_stall();
    bus.respond_rule__ENA = 1'b1;
    bus.ind_heard__RDY    = 1'b0;
    bus.say__ENA          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.say_v = 32'h31 + i;
      tick();
    end
    bus.say__ENA = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.ind_heard__ENA !== 1'b0 || bus.count !== 3'd3) begin
        n_fail++;
        $display("FAIL stall[%0d]: ena=%b count=%0d want 0 3", i, bus.ind_heard__ENA, bus.count);
      end
      tick();
    end
    bus.ind_heard__RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_v !== 32'h31 + i) begin
        n_fail++;
        $display("FAIL resume[%0d]: ena=%b data=%h want 1 %h",
                 i, bus.ind_heard__ENA, bus.ind_heard_heard_v, 32'h31 + i);
      end
      tick();
    end
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL resume_empty: count=%0d want 0", bus.count);
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.say__ENA = 1'b1;
    bus.say_v    = 32'h41;
    tick();
    bus.say_v = 32'h42;
    tick();
    bus.say__ENA          = 1'b0;
    bus.respond_rule__ENA = 1'b1;
    bus.ind_heard__RDY    = 1'b1;
    #1;
    n_checks++;
    if (bus.count !== 3'd2 || bus.ind_heard__ENA !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: count=%0d ena=%b want 2 1", bus.count, bus.ind_heard__ENA);
    end
    nRST = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.say__RDY !== 1'b1 || bus.ind_heard__ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d say_rdy=%b ena=%b want 0 1 0",
               bus.count, bus.say__RDY, bus.ind_heard__ENA);
    end
    idle();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    bus.say__ENA          = 1'b1;
    bus.say_v             = 32'hAB;
    bus.respond_rule__ENA = 1'b1;
    bus.ind_heard__RDY    = 1'b1;
    @(negedge CLK);
`ifdef ECHO_QUEUE_BYPASS_EN
    n_checks++;
    if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_v !== 32'hAB) begin
      n_fail++;
      $display("FAIL bypass_same: ena=%b data=%h want 1 ab", bus.ind_heard__ENA, bus.ind_heard_heard_v);
    end
    tick();
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL bypass_count: count=%0d want 0", bus.count);
    end
`else
    n_checks++;
    if (bus.ind_heard__ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_same: ena=%b want 0", bus.ind_heard__ENA);
    end
    tick();
    n_checks++;
    if (bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL nobypass_count: count=%0d want 1", bus.count);
    end
    bus.say__ENA = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_heard_v !== 32'hAB) begin
      n_fail++;
      $display("FAIL nobypass_next: ena=%b data=%h want 1 ab", bus.ind_heard__ENA, bus.ind_heard_heard_v);
    end
    tick();
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL nobypass_drain: count=%0d want 0", bus.count);
    end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
